// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Handles three events in RUN, in priority order: a multi-cycle data-memory
// access, a branch mispredict resolved in EX, and a load-use hazard in ID.
// It also keeps saturating hazard statistics and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_mispredict,
    input  logic [31:0]      ex_target,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write_en,
    output logic             write_if_id,
    output logic             write_id_ex,
    output logic             write_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    // Wide enough to hold MEM_TIMEOUT itself; the counter parks there.
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            lu;
    logic            inc_stall;
    logic            inc_flush;
    logic            inc_memwait;
    logic            to_load;
    logic            to_inc;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_nxt;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    // x0 is never a real dependency.
    always_comb begin
        lu = ex_memread && (ex_rd != 5'd0) &&
             ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    end

    // Next-state and pipeline control outputs; defaults describe a normal advance.
    always_comb begin
        state_nxt      = state;
        pc_write_en    = 1'b1;
        write_if_id    = 1'b1;
        write_id_ex    = 1'b1;
        write_ex_mem   = 1'b1;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inc_stall      = 1'b0;
        inc_flush      = 1'b0;
        inc_memwait    = 1'b0;
        to_load        = 1'b0;
        to_inc         = 1'b0;

        if (rst) begin
            // Hold every register and keep NOPs/bubbles flowing while in reset.
            pc_write_en  = 1'b0;
            write_if_id  = 1'b0;
            write_id_ex  = 1'b0;
            write_ex_mem = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        // Freeze the whole pipe until memory answers.
                        pc_write_en  = 1'b0;
                        write_if_id  = 1'b0;
                        write_id_ex  = 1'b0;
                        write_ex_mem = 1'b0;
                        to_load      = 1'b1;
                        state_nxt    = MEM_WAIT;
                    end else if (ex_mispredict) begin
                        // Kill IF and ID; any load-use on the ID instruction is moot.
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        inc_flush      = 1'b1;
                    end else if (lu) begin
                        // Hold IF/ID for one cycle and insert a bubble into EX.
                        pc_write_en = 1'b0;
                        write_if_id = 1'b0;
                        flush_id_ex = 1'b1;
                        inc_stall   = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    inc_memwait = 1'b1;
                    to_inc      = 1'b1;
                    if (mem_ready) begin
                        // Completion cycle advances normally; EX/ID re-present next cycle.
                        state_nxt = RUN;
                    end else begin
                        pc_write_en  = 1'b0;
                        write_if_id  = 1'b0;
                        write_id_ex  = 1'b0;
                        write_ex_mem = 1'b0;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Next timeout count: restart at 1 on entry, otherwise count up and park at the limit.
    always_comb begin
        if (to_load) begin
            to_nxt = TO_W'(1);
        end else if (to_cnt >= TO_LIM) begin
            to_nxt = to_cnt;
        end else begin
            to_nxt = to_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else if (to_load || to_inc) begin
            to_cnt <= to_nxt;
            if (to_nxt >= TO_LIM) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating hazard statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if (inc_stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (inc_flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
            if (inc_memwait) begin
                memwait_cnt <= sat_inc(memwait_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. Two instances share the stimulus:
// one with default parameters, one with CNT_W=2 / MEM_TIMEOUT=4 so that
// saturation and timeout are reachable quickly.
module tb_pipeline_hazard_ctrl;

    localparam int MT_L  = 64;
    localparam int MT_S  = 4;
    localparam int MAX_L = 65535;
    localparam int MAX_S = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs2 = 1'b0, ex_memread = 1'b0, ex_mispredict = 1'b0;
    logic [31:0] ex_target = '0;
    logic        mem_req = 1'b0, mem_ready = 1'b0;

    logic        pcw_l, wifid_l, widex_l, wexm_l, fifid_l, fidex_l, rv_l, to_l;
    logic [31:0] rpc_l;
    logic [15:0] stall_l, flush_l, mw_l;
    logic        pcw_s, wifid_s, widex_s, wexm_s, fifid_s, fidex_s, rv_s, to_s;
    logic [31:0] rpc_s;
    logic [1:0]  stall_s, flush_s, mw_s;

    pipeline_hazard_ctrl dut_l (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mispredict(ex_mispredict),
        .ex_target(ex_target), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pcw_l), .write_if_id(wifid_l), .write_id_ex(widex_l),
        .write_ex_mem(wexm_l), .flush_if_id(fifid_l), .flush_id_ex(fidex_l),
        .redirect_valid(rv_l), .redirect_pc(rpc_l), .mem_timeout(to_l),
        .stall_cnt(stall_l), .flush_cnt(flush_l), .memwait_cnt(mw_l)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(MT_S)) dut_s (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mispredict(ex_mispredict),
        .ex_target(ex_target), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pcw_s), .write_if_id(wifid_s), .write_id_ex(widex_s),
        .write_ex_mem(wexm_s), .flush_if_id(fifid_s), .flush_id_ex(fidex_s),
        .redirect_valid(rv_s), .redirect_pc(rpc_s), .mem_timeout(to_s),
        .stall_cnt(stall_s), .flush_cnt(flush_s), .memwait_cnt(mw_s)
    );

    always #5 clk = ~clk;

    // Expected DUT view for one cycle.
    typedef struct {
        logic [6:0]  ctl;   // {pc_we, w_if_id, w_id_ex, w_ex_mem, fl_if_id, fl_id_ex, redirect}
        logic [31:0] rpc;
        logic        tol, tos;
        int          stl, fll, mwl, sts, fls, mws;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Next-cycle stimulus, set by the test sequence and applied by cyc().
    logic        n_rst = 1'b1, n_uses = 1'b0, n_mr = 1'b0, n_mp = 1'b0, n_req = 1'b0, n_rdy = 1'b0;
    logic [4:0]  n_rs1 = '0, n_rs2 = '0, n_rd = '0;
    logic [31:0] n_tgt = '0;

    // Reference model state: waiting flag, length of the current memory stall
    // episode in cycles, statistics as plain integers.
    bit m_wait = 0;
    int m_len  = 0;
    int m_stl = 0, m_fll = 0, m_mwl = 0, m_sts = 0, m_fls = 0, m_mws = 0;
    bit m_tol = 0, m_tos = 0;

    function automatic int sat(int v, int mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, predict the response, advance the model.
    task automatic cyc();
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst = n_rst; id_rs1 = n_rs1; id_rs2 = n_rs2; id_uses_rs2 = n_uses;
        ex_rd = n_rd; ex_memread = n_mr; ex_mispredict = n_mp; ex_target = n_tgt;
        mem_req = n_req; mem_ready = n_rdy;

        if (n_rst) begin
            m_wait = 0; m_len = 0; m_tol = 0; m_tos = 0;
            m_stl = 0; m_fll = 0; m_mwl = 0; m_sts = 0; m_fls = 0; m_mws = 0;
            e.ctl = 7'b0000_110; e.rpc = 0;
        end else begin
            lu = n_mr && n_rd != 0 && (n_rd == n_rs1 || (n_uses && n_rd == n_rs2));
            if (m_wait) e.ctl = n_rdy ? 7'b1111_000 : 7'b0000_000;
            else if (n_req && !n_rdy) e.ctl = 7'b0000_000;
            else if (n_mp) e.ctl = 7'b1111_111;
            else if (lu) e.ctl = 7'b0011_010;
            else e.ctl = 7'b1111_000;
            e.rpc = (!m_wait && !(n_req && !n_rdy) && n_mp) ? n_tgt : 32'd0;
        end
        e.tol = m_tol; e.tos = m_tos;
        e.stl = m_stl; e.fll = m_fll; e.mwl = m_mwl;
        e.sts = m_sts; e.fls = m_fls; e.mws = m_mws;
        q.push_back(e);

        if (!n_rst) begin
            if (m_wait) begin
                m_mwl = sat(m_mwl, MAX_L); m_mws = sat(m_mws, MAX_S);
                m_len++;
                if (n_rdy) m_wait = 0;
            end else if (n_req && !n_rdy) begin
                m_wait = 1; m_len = 1;
            end else if (n_mp) begin
                m_fll = sat(m_fll, MAX_L); m_fls = sat(m_fls, MAX_S);
            end else if (lu) begin
                m_stl = sat(m_stl, MAX_L); m_sts = sat(m_sts, MAX_S);
            end
            if (m_len >= MT_L) m_tol = 1;
            if (m_len >= MT_S) m_tos = 1;
            if (!m_wait) m_len = 0;
        end
    endtask

    task automatic idle(int n);
        n_rst = 0; n_rs1 = 0; n_rs2 = 0; n_uses = 0; n_rd = 0; n_mr = 0;
        n_mp = 0; n_tgt = 0; n_req = 0; n_rdy = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Monitor: the outputs are valid every cycle, so pop one entry per cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctl_l", {pcw_l, wifid_l, widex_l, wexm_l, fifid_l, fidex_l, rv_l}, e.ctl);
            chk("ctl_s", {pcw_s, wifid_s, widex_s, wexm_s, fifid_s, fidex_s, rv_s}, e.ctl);
            chk("rpc_l", rpc_l, e.rpc);
            chk("rpc_s", rpc_s, e.rpc);
            chk("timeout_l", to_l, e.tol);
            chk("timeout_s", to_s, e.tos);
            chk("stall_l", stall_l, e.stl);
            chk("flush_l", flush_l, e.fll);
            chk("memwait_l", mw_l, e.mwl);
            chk("stall_s", stall_s, e.sts);
            chk("flush_s", flush_s, e.fls);
            chk("memwait_s", mw_s, e.mws);
        end
    end

    initial begin
        int hold;
        // Reset, then a quiet stretch.
        n_rst = 1; cyc(); cyc();
        idle(10);

        // Load-use via rs2, then rs2 not used, then ex_rd = x0.
        n_mr = 1; n_rd = 5; n_rs2 = 5; n_uses = 1; n_rs1 = 1; cyc();
        idle(2);
        n_mr = 1; n_rd = 5; n_rs2 = 5; n_uses = 0; n_rs1 = 1; cyc();
        idle(2);
        n_mr = 1; n_rd = 0; n_rs1 = 0; n_rs2 = 0; n_uses = 1; cyc();
        idle(2);

        // Mispredict together with a load-use.
        n_mp = 1; n_tgt = 32'h0000_0040; n_mr = 1; n_rd = 7; n_rs1 = 7; cyc();
        idle(2);

        // Memory wait with a mispredict held throughout.
        n_rst = 1; cyc(); idle(1);
        n_mp = 1; n_tgt = 32'h0000_1234; n_req = 1; n_rdy = 0;
        for (int i = 0; i < 3; i++) cyc();
        n_rdy = 1; cyc();
        n_req = 0; n_rdy = 0; cyc();
        idle(2);

        // Timeout on the small instance, stickiness, then reset mid-wait.
        n_rst = 1; cyc(); idle(1);
        n_req = 1; n_rdy = 0;
        for (int i = 0; i < 6; i++) cyc();
        n_rdy = 1; cyc();
        idle(3);
        n_req = 1; n_rdy = 0; cyc(); cyc();
        n_rst = 1; cyc();
        n_rst = 0; cyc(); cyc();
        idle(2);

        // Five load-use stalls: the 2-bit counter sticks at 3.
        for (int i = 0; i < 5; i++) begin
            n_mr = 1; n_rd = 9; n_rs1 = 9; cyc();
            idle(1);
        end

        // Randomized traffic, including waits long enough for the default timeout.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            n_rst  = ($urandom_range(0, 399) == 0);
            n_rs1  = 5'($urandom_range(0, 3));
            n_rs2  = 5'($urandom_range(0, 3));
            n_rd   = 5'($urandom_range(0, 3));
            n_uses = 1'($urandom_range(0, 1));
            n_mr   = ($urandom_range(0, 2) == 0);
            n_mp   = ($urandom_range(0, 5) == 0);
            n_tgt  = $urandom;
            n_req  = ($urandom_range(0, 3) == 0);
            if (hold == 0 && $urandom_range(0, 299) == 0) hold = 70;
            if (hold > 0) begin
                n_rdy = 0; n_req = 1; n_rst = 0; hold--;
            end else begin
                n_rdy = ($urandom_range(0, 2) == 0);
            end
            cyc();
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline. It sequences the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. Three events drive it: load-use hazards from decode, branch mispredictions resolved in EX, and multi-cycle data-memory accesses. It drives the `pc_write_en` / `write_if_id` enables, bubble/flush controls and the fetch redirect, and keeps hazard statistics.

Parameters:
- CNT_W, 16, width of the statistics counters (saturating).
- MEM_TIMEOUT, 64, max cycles in MEM_WAIT before `mem_timeout` is raised.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types).
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_mispredict  in  1  branch in EX resolved opposite to its prediction.
- ex_target  in  32  correct next PC for the mispredicted branch.
- mem_req  in  1  MEM stage holds a load/store this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write_en  out  1  PC register load enable.
- write_if_id  out  1  IF/ID load enable.
- write_id_ex  out  1  ID/EX load enable.
- write_ex_mem  out  1  EX/MEM load enable.
- flush_if_id  out  1  load a NOP into IF/ID.
- flush_id_ex  out  1  load a bubble (all controls 0) into ID/EX.
- redirect_valid  out  1  next_pc mux selects `redirect_pc`.
- redirect_pc  out  32  fetch redirect target.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  mispredict flushes.
- memwait_cnt  out  CNT_W  MEM_WAIT cycles.

Behaviour:
- States: RUN, MEM_WAIT. Outputs are combinational from state and inputs. Counters, the timeout counter and `mem_timeout` are registered.
- Reset (async, any cycle, including mid-MEM_WAIT):
  - state=RUN; all counters=0; `mem_timeout`=0.
  - While `rst`=1: all write enables 0, both flushes 1, `redirect_valid`=0.
- Load-use hazard (`lu`) = `ex_memread` && `ex_rd`!=0 && (`ex_rd`==`id_rs1` || (`id_uses_rs2` && `ex_rd`==`id_rs2`)).
- Event priority within RUN: memory wait > mispredict > load-use > normal.
  - RUN, `mem_req` && !`mem_ready`:
    - All four write enables 0, no flush, no redirect.
    - Next state = MEM_WAIT; timeout counter := 1.
  - RUN, `ex_mispredict` (memory not stalling):
    - All write enables 1; `flush_if_id`=1, `flush_id_ex`=1.
    - `redirect_valid`=1, `redirect_pc`=`ex_target`.
    - `flush_cnt`++. Any simultaneous `lu` is ignored, because the ID instruction is being killed.
  - RUN, `lu` only:
    - `pc_write_en`=0, `write_if_id`=0.
    - `write_id_ex`=1 with `flush_id_ex`=1 (bubble); `write_ex_mem`=1.
    - `stall_cnt`++. The stall lasts exactly one cycle, because the load advances to MEM on that edge.
  - RUN, no event: all enables 1, no flush, `redirect_valid`=0, `redirect_pc`=0.
- MEM_WAIT:
  - All write enables 0; flushes 0; `redirect_valid`=0.
  - `ex_mispredict` and `lu` are ignored: EX/ID are frozen and re-present on exit.
  - `memwait_cnt`++ per cycle; timeout counter++.
  - On `mem_ready`=1: the same cycle drives RUN outputs (all enables 1, so EX/MEM advances), then next state = RUN.
  - When timeout counter reaches MEM_TIMEOUT: `mem_timeout` := 1 (sticky until reset); the state remains MEM_WAIT.
- All statistics counters saturate at 2^CNT_W−1 (no wrap).
- `mem_req`=1 with `mem_ready`=1 in RUN is a zero-wait access and causes no stall.
- `ex_rd`=x0 never causes a stall.

Test Plan:
- Reset release, no hazards, 10 cycles → all enables 1, flushes 0, all counters 0.
- `ex_memread`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 for one cycle → `pc_write_en`=0, `write_if_id`=0, `flush_id_ex`=1; `stall_cnt`=1. Repeat with `id_uses_rs2`=0 → no stall. Repeat with `ex_rd`=0 → no stall.
- `ex_mispredict`=1, `ex_target`=0x0000_0040, with `lu` also true → `redirect_valid`=1, `redirect_pc`=0x40, both flushes 1, `pc_write_en`=1; `flush_cnt`=1, `stall_cnt` unchanged.
- `mem_req`=1, `mem_ready`=0 for 3 cycles, then `mem_ready`=1; `ex_mispredict` held 1 throughout → enables 0 for 3 cycles; no redirect during the wait; `memwait_cnt`=3; RUN afterwards, where the mispredict then redirects.
- MEM_TIMEOUT=4, `mem_ready` held 0 → `mem_timeout`=1 after the 4th wait cycle. It stays 1 after `mem_ready`; async `rst` mid-wait clears it and returns the state to RUN immediately.
- CNT_W=2, 5 load-use stalls → `stall_cnt` saturates at 3.
